// File: rtl/k_loop_pkg.sv
// Shared types and default widths for the K-limit loop controller and its comparator.
package k_loop_pkg;

    localparam int unsigned DefW  = 6;
    localparam int unsigned DefCw = 6;

    typedef enum logic [1:0] {
        GT  = 2'd0,
        GE  = 2'd1,
        EQ  = 2'd2,
        SGT = 2'd3
    } cmp_mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } loop_state_t;

endpackage

// File: rtl/k_cmp_core.sv
// Combinational limit comparator: hit when acc has passed or reached K under the chosen mode.
import k_loop_pkg::*;

module k_cmp_core #(
    parameter int unsigned W = DefW
) (
    input  logic [W-1:0] k,
    input  logic [W-1:0] acc,
    input  cmp_mode_t    mode,
    output logic         hit
);

    always_comb begin
        hit = 1'b0;
        unique case (mode)
            GT:      hit = (k < acc);
            GE:      hit = (k <= acc);
            EQ:      hit = (k == acc);
            SGT:     hit = ($signed(k) < $signed(acc));
            default: hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/k_loop_compare.sv
// Loop-termination controller: steps an accumulator on each adv strobe until it meets the
// latched limit K, then pulses done with the iteration count and overflow flag.
import k_loop_pkg::*;

module k_loop_compare #(
    parameter int unsigned W  = DefW,
    parameter int unsigned CW = DefCw
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          adv,
    input  logic [1:0]    mode,
    input  logic [W-1:0]  k_in,
    input  logic [W-1:0]  init_in,
    input  logic [W-1:0]  step_in,
    output logic          busy,
    output logic          done,
    output logic          comp_out,
    output logic [W-1:0]  acc_out,
    output logic [CW-1:0] iter_out,
    output logic          ovf
);

    loop_state_t   state_q, state_d;
    cmp_mode_t     mode_q, mode_d;
    logic [W-1:0]  k_q, k_d;
    logic [W-1:0]  step_q, step_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [CW-1:0] iter_q, iter_d;
    logic          ovf_q, ovf_d;
    logic          hit;
    logic [W:0]    sum;

    // Extra top bit is the carry that signals accumulator overflow.
    assign sum = {1'b0, acc_q} + {1'b0, step_q};

    k_cmp_core #(
        .W (W)
    ) u_cmp (
        .k    (k_q),
        .acc  (acc_q),
        .mode (mode_q),
        .hit  (hit)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        k_d     = k_q;
        step_d  = step_q;
        acc_d   = acc_q;
        iter_d  = iter_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d  = cmp_mode_t'(mode);
                    k_d     = k_in;
                    step_d  = step_in;
                    acc_d   = init_in;
                    iter_d  = '0;
                    ovf_d   = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // The compare sees the registered acc, so a hit wins over a same-cycle adv.
                if (abort) begin
                    state_d = IDLE;
                end else if (hit) begin
                    state_d = DONE;
                end else if (adv) begin
                    iter_d = (&iter_q) ? iter_q : iter_q + 1'b1;
                    if (sum[W]) begin
                        acc_d   = '1;
                        ovf_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        acc_d = sum[W-1:0];
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= GT;
            k_q     <= '0;
            step_q  <= '0;
            acc_q   <= '0;
            iter_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            k_q     <= k_d;
            step_q  <= step_d;
            acc_q   <= acc_d;
            iter_q  <= iter_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign comp_out = (state_q != IDLE) && hit;
    assign acc_out  = acc_q;
    assign iter_out = iter_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_k_loop_compare.sv
// Randomised and directed bench for k_loop_compare against an arithmetic reference model.
module tb_k_loop_compare;

    localparam int W    = 6;
    localparam int CW   = 6;
    localparam int MAXV = (1 << W) - 1;
    localparam int MAXI = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          adv = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [W-1:0]  k_in = '0;
    logic [W-1:0]  init_in = '0;
    logic [W-1:0]  step_in = '0;
    logic          busy, done, comp_out, ovf;
    logic [W-1:0]  acc_out;
    logic [CW-1:0] iter_out;

    int total = 0;
    int passed = 0;

    k_loop_compare #(.W(W), .CW(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .adv      (adv),
        .mode     (mode),
        .k_in     (k_in),
        .init_in  (init_in),
        .step_in  (step_in),
        .busy     (busy),
        .done     (done),
        .comp_out (comp_out),
        .acc_out  (acc_out),
        .iter_out (iter_out),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: phase 0 idle, 1 looping, 2 reporting.
    int m_phase, m_k, m_step, m_mode, m_acc, m_iter, m_ovf;

    function automatic int as_signed(input int v);
        return (v >= (1 << (W - 1))) ? v - (1 << W) : v;
    endfunction

    function automatic bit model_hit(input int k, input int a, input int md);
        if (md == 0) return k < a;
        if (md == 1) return k <= a;
        if (md == 2) return k == a;
        return as_signed(k) < as_signed(a);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0; m_k = 0; m_step = 0; m_mode = 0; m_acc = 0; m_iter = 0; m_ovf = 0;
        end else if (m_phase == 0) begin
            if (start) begin
                m_k = int'(k_in); m_step = int'(step_in); m_mode = int'(mode);
                m_acc = int'(init_in); m_iter = 0; m_ovf = 0; m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (abort) m_phase = 0;
            else if (model_hit(m_k, m_acc, m_mode)) m_phase = 2;
            else if (adv) begin
                if (m_iter < MAXI) m_iter = m_iter + 1;
                if (m_acc + m_step > MAXV) begin
                    m_acc = MAXV; m_ovf = 1; m_phase = 2;
                end else m_acc = m_acc + m_step;
            end
        end else m_phase = 0;
    end

    always @(negedge clk) begin
        chk("busy", int'(busy), int'(m_phase == 1));
        chk("done", int'(done), int'(m_phase == 2));
        chk("comp_out", int'(comp_out), int'(m_phase != 0 && model_hit(m_k, m_acc, m_mode)));
        chk("acc_out", int'(acc_out), m_acc);
        chk("iter_out", int'(iter_out), m_iter);
        chk("ovf", int'(ovf), m_ovf);
    end

    task automatic start_loop(input int md, input int k, input int ini, input int st);
        @(negedge clk); #1;
        mode = 2'(md); k_in = W'(k); init_in = W'(ini); step_in = W'(st); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Counts negedges after the start edge until done is seen; -1 if the bound expires.
    task automatic wait_done(input int bound, output int n);
        n = -1;
        for (int i = 1; i <= bound; i++) begin
            @(negedge clk);
            if (done) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin : stim
        int n;
        int exp_acc[6];
        int seen;
        exp_acc = '{0, 3, 6, 9, 12, 12};

        #12 rst = 1'b0;
        @(negedge clk);
        chk("reset_acc", int'(acc_out), 0);
        chk("reset_busy", int'(busy), 0);

        // Basic GT loop with a start pulse mid-loop that must be ignored.
        adv = 1'b1;
        start_loop(0, 10, 0, 3);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            chk("t2_acc", int'(acc_out), exp_acc[i-1]);
            chk("t2_done", int'(done), int'(i == 6));
            chk("t2_comp", int'(comp_out), int'(i >= 5));
            #1;
            if (i == 2) begin start = 1'b1; k_in = '0; init_in = 6'd50; end
            if (i == 3) start = 1'b0;
        end
        chk("t2_iter", int'(iter_out), 4);
        chk("t2_ovf", int'(ovf), 0);
        @(negedge clk);
        chk("t2_single_pulse", int'(done), 0);
        chk("t2_hold_acc", int'(acc_out), 12);

        start_loop(0, 63, 60, 5);
        wait_done(20, n);
        chk("t3_latency", n, 2);
        chk("t3_acc", int'(acc_out), 63);
        chk("t3_ovf", int'(ovf), 1);
        chk("t3_iter", int'(iter_out), 1);

        start_loop(3, 'h3C, 'h38, 1);
        wait_done(30, n);
        chk("t4_latency", n, 7);
        chk("t4_acc", int'(acc_out), 'h3D);
        chk("t4_iter", int'(iter_out), 5);

        start_loop(2, 7, 0, 2);
        wait_done(100, n);
        chk("t5_latency", n, 33);
        chk("t5_acc", int'(acc_out), 63);
        chk("t5_ovf", int'(ovf), 1);
        chk("t5_iter", int'(iter_out), 32);

        // Gaps in adv must freeze the accumulator.
        adv = 1'b0;
        start_loop(0, 10, 4, 3);
        repeat (3) @(negedge clk);
        chk("gap_acc", int'(acc_out), 4);
        chk("gap_busy", int'(busy), 1);
        #1 adv = 1'b1;
        @(negedge clk);
        chk("gap_step", int'(acc_out), 7);
        wait_done(20, n);
        chk("gap_finished", int'(n > 0), 1);

        // Abort at acc=6.
        start_loop(0, 10, 0, 3);
        repeat (3) @(negedge clk);
        chk("abort_pre_acc", int'(acc_out), 6);
        #1 abort = 1'b1; adv = 1'b0;
        @(negedge clk);
        #1 abort = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_acc", int'(acc_out), 6);
        wait_done(5, n);
        chk("abort_no_done", n, -1);

        // Init already beyond K terminates without stepping.
        adv = 1'b1;
        start_loop(0, 10, 12, 3);
        wait_done(10, n);
        chk("early_latency", n, 2);
        chk("early_iter", int'(iter_out), 0);

        // Asynchronous reset mid-loop.
        start_loop(0, 60, 0, 1);
        repeat (3) @(negedge clk);
        @(posedge clk); #2 rst = 1'b1;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_comp", int'(comp_out), 0);
        chk("rst_acc", int'(acc_out), 0);
        chk("rst_iter", int'(iter_out), 0);
        chk("rst_ovf", int'(ovf), 0);
        @(negedge clk); #1 rst = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("rst_no_done", seen, 0);

        // Random traffic, checked every cycle by the model.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk); #1;
            start   = ($urandom_range(0, 3) == 0);
            abort   = ($urandom_range(0, 31) == 0);
            adv     = ($urandom_range(0, 3) != 0);
            mode    = 2'($urandom_range(0, 3));
            k_in    = W'($urandom);
            init_in = W'($urandom);
            step_in = W'($urandom_range(0, 9));
        end
        start = 1'b0; abort = 1'b0; adv = 1'b0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/k_loop_compare.md
Name: k_loop_compare

Overview:
- Parametrised sequential successor to the team's single-shot "K < accumulator" comparator.
- Owns the loop-termination path: latches a limit K, steps an internal accumulator by a programmable step on each datapath strobe, and compares it against K under a selectable mode.
- Signals termination with a one-cycle done pulse, reporting iteration count and overflow.
- Sits between the iterative datapath (adder) and its controlling FSM.

Parameters:
- W, 6, width of K, init, step and accumulator.
- CW, 6, width of iteration counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  begin a loop; sampled in IDLE only.
- abort  in  1  cancel a loop; honoured in RUN only.
- adv  in  1  datapath iteration strobe.
- mode  in  2  compare mode, latched on start.
- k_in  in  W  limit K, latched on start.
- init_in  in  W  accumulator start value, latched on start.
- step_in  in  W  unsigned increment, latched on start.
- busy  out  1  high in RUN.
- done  out  1  one-cycle termination pulse.
- comp_out  out  1  compare result of current accumulator; 0 in IDLE.
- acc_out  out  W  accumulator value.
- iter_out  out  CW  accepted adv count, saturating at all-ones.
- ovf  out  1  accumulator carry-out occurred; sticky until next start.

Behaviour:
- Reset (async, any state): state=IDLE; busy, done, comp_out, ovf = 0; acc_out, iter_out = 0; latched K, step and mode = 0.
- Compare modes:
  - 0 GT: K < acc, unsigned.
  - 1 GE: K <= acc, unsigned.
  - 2 EQ: K == acc.
  - 3 SGT: K < acc, two's complement.
- comp_out is a combinational function of the registered acc, K and mode, gated to 0 in IDLE.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 → latch k_in, init_in, step_in and mode; acc=init_in, iter=0, ovf=0; next RUN.
  - abort is ignored in IDLE.
- RUN, priority order:
  1. abort=1 → IDLE; no done; acc_out and iter_out hold.
  2. comp_out=1 → DONE; adv ignored this cycle.
  3. adv=1 → form the W+1-bit sum acc+step.
     - Carry=1 → acc=all-ones (saturate), ovf=1, next DONE.
     - Else acc=sum.
     - In both cases iter+1, saturating.
  4. adv=0 → hold.
- The compare always evaluates the registered acc. A hit is therefore detected one cycle after the adv that produced it.
- An init value that already satisfies the compare terminates in the first RUN cycle with iter=0.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - busy=0.
  - start in DONE is ignored.
- Results: acc_out, iter_out and ovf hold from DONE through IDLE until the next start.
- Latency: start → RUN is 1 cycle. Hit → done is 1 cycle.
- start during RUN or DONE is ignored, and latched operands never change mid-loop.
- Reset mid-loop: immediate IDLE, all outputs 0, no done pulse.

Decomposition:
- Shared package k_loop_pkg:
  - cmp_mode_t enum: GT=0, GE=1, EQ=2, SGT=3.
  - loop_state_t enum: IDLE, RUN, DONE.
  - Default width constants.
- One sub-module, k_cmp_core: parametrised (W) combinational comparator taking K, acc and mode and producing the hit. It is reusable by other loop controllers.
- k_loop_compare itself contains the FSM, accumulator and counter.

Test Plan:
1. Reset: assert rst mid-RUN → same cycle busy=0, done=0, comp_out=0, acc_out=0, iter_out=0, ovf=0. No done pulse afterwards.
2. mode=0, K=10, init=0, step=3, adv held high, start at cycle 0:
   - acc 0,3,6,9,12 on cycles 1–5.
   - comp_out=1 at cycle 5; done pulse at cycle 6 only.
   - iter_out=4, ovf=0.
3. Overflow: mode=0, K=63, init=60, step=5, adv=1 → acc_out=63, ovf=1, done next cycle, iter_out=1.
4. Signed: mode=3, K=0x3C (-4), init=0x38 (-8), step=1, adv=1 → hit at acc=0x3D (-3), iter_out=5.
5. EQ miss: mode=2, K=7, init=0, step=2 → never equal; overflow on 32nd adv, acc_out=63, ovf=1, iter_out=32.
6. Control and edge cases:
   - adv gaps: acc holds while adv=0.
   - abort in RUN at acc=6 → IDLE, no done, acc_out=6.
   - start while busy is ignored.
   - start with init=12 > K=10 (mode 0) → done 2 cycles after start, iter_out=0.
